bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
Master-side front end of the shared system bus. It arbitrates between two bus masters (m0, m1) and forwards the granted master's request, address, write strobe and write data to the address decoder and slaves. It returns slave read data to the masters using the decoder's slave selects, delayed by one cycle. It is the initiator-side counterpart of the slave-select decoder: the decoder consumes this block's m_req/m_address, and its s0_sel/s1_sel come back here.

Parameters:
ADDR_W, 16, bus address width
DATA_W, 32, bus data width
MAX_HOLD, 16, max consecutive grant cycles for one master while the other is requesting (>=2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
m0_req  input  1  master 0 bus request
m0_wr  input  1  master 0 write strobe (1=write, 0=read)
m0_address  input  ADDR_W  master 0 address
m0_dout  input  DATA_W  master 0 write data
m1_req  input  1  master 1 bus request
m1_wr  input  1  master 1 write strobe
m1_address  input  ADDR_W  master 1 address
m1_dout  input  DATA_W  master 1 write data
m0_grant  output  1  master 0 owns bus
m1_grant  output  1  master 1 owns bus
m_req  output  1  forwarded request to decoder/slaves
m_wr  output  1  forwarded write strobe
m_address  output  ADDR_W  forwarded address
m_dout  output  DATA_W  forwarded write data
s0_sel  input  1  slave 0 select from decoder
s1_sel  input  1  slave 1 select from decoder
s0_dout  input  DATA_W  slave 0 read data, valid 1 cycle after select
s1_dout  input  DATA_W  slave 1 read data, valid 1 cycle after select
m_din  output  DATA_W  read data to both masters

Behaviour:
- Reset (async, active-high): state=IDLE, grants=0, hold_cnt=0, last_grant=1 (m0 wins the first tie), rd_sel=2'b00. m_req/m_wr/m_address/m_dout/m_din are all 0.
- FSM states: IDLE, GRANT0, GRANT1. Grants are registered Moore outputs: m0_grant=(state==GRANT0), m1_grant=(state==GRANT1).
- IDLE: only m0_req -> GRANT0. Only m1_req -> GRANT1. Both -> the master other than last_grant. Neither -> IDLE. Grant asserts the cycle after the request is seen.
- GRANTx, mx_req low: other requesting -> GRANTother next cycle (no IDLE bubble). Otherwise -> IDLE.
- GRANTx, mx_req high, other requesting, hold_cnt==MAX_HOLD-1 -> GRANTother (forced handover). Otherwise stay.
- GRANTx, other not requesting: stay indefinitely; hold_cnt saturates at MAX_HOLD-1.
- hold_cnt: width $clog2(MAX_HOLD). Cleared on every grant change and in IDLE. Increments each cycle in GRANTx.
- last_grant updates to x on each entry to GRANTx.
- Forward mux (combinational from state):
  - GRANT0: m_req=m0_req, m_wr=m0_wr, m_address=m0_address, m_dout=m0_dout.
  - GRANT1: the same fields from m1.
  - IDLE: all forward outputs 0.
  - A deasserted req in the granted state yields m_req=0, so no spurious decoder select.
- Read return: rd_sel<={s1_sel,s0_sel} & {~m_wr,~m_wr} every cycle (reads only). m_din=s0_dout if rd_sel==01, s1_dout if 10, else 0. 2'b11 (illegal) -> 0.
- Read latency: address presented in cycle N -> m_din valid in cycle N+1. A grant switch in cycle N+1 does not corrupt the N+1 return data.
- Reset mid-transfer: all outputs clear immediately (asynchronous). An in-flight read return is dropped.

Decomposition:
- Shared bus package/header: ADDR_W, DATA_W, FSM state encodings (IDLE=2'b00, GRANT0=2'b01, GRANT1=2'b10), slave select codes.
- One natural sub-module, bus_rdata_mux: rd_sel register plus read-data select. The FSM and forward mux stay in the top module.

Test Plan:
- Reset with m0_req=1 -> m0_grant=0, m_req=0, m_din=0; after reset release, m0_grant=1 one cycle later.
- m0_req and m1_req asserted together from IDLE -> GRANT0 first; m0 drops req -> m1_grant=1 next cycle with no IDLE cycle.
- m0 holds req, m1_req high, MAX_HOLD=16 -> m0_grant high exactly 16 cycles, then m1_grant=1; m1 holds -> m0 is regranted after 16 cycles.
- m1 alone holds for 40 cycles -> m1_grant stays 1 throughout, hold_cnt saturates at 15.
- GRANT0 read of m0_address=16'h0010, s0_sel=1, s0_dout=32'hDEADBEEF next cycle -> m_din=32'hDEADBEEF one cycle after the address. Repeat at 16'h7004 with s1_dout=32'h12345678 -> m_din=32'h12345678.
- Write with m0_wr=1 to 16'h0020 -> m_din stays 0. Decoder selects neither slave (address 16'h0900) -> m_din=0. Async reset pulse mid-GRANT1 -> all outputs 0 within the same cycle.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// bus_arbiter_pkg
// Shared definitions for the master-side bus front end: default bus widths,
// arbiter FSM state encoding and the read-return slave select codes.
// ---------------------------------------------------------------------------
package bus_arbiter_pkg;

    localparam int BUS_ADDR_W = 16;
    localparam int BUS_DATA_W = 32;

    // Arbiter states; encoding is shared with other bus blocks.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_GRANT0 = 2'b01,
        ST_GRANT1 = 2'b10
    } arb_state_t;

    // Registered {s1_sel, s0_sel} codes used on the read-return path.
    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_S0   = 2'b01;
    localparam logic [1:0] SEL_S1   = 2'b10;

endpackage

// File: rtl/bus_rdata_mux.sv
// ---------------------------------------------------------------------------
// bus_rdata_mux
// Read-data return path. Registers the decoder's slave selects (reads only)
// and uses them one cycle later to pick which slave's read data reaches the
// masters.
//   clk, reset         : clock, async active-high reset
//   s0_sel, s1_sel     : slave selects from the address decoder
//   m_wr               : forwarded write strobe (writes return no data)
//   s0_dout, s1_dout   : slave read data, valid one cycle after select
//   m_din              : read data to both masters
// ---------------------------------------------------------------------------
module bus_rdata_mux
    import bus_arbiter_pkg::*;
#(
    parameter int DATA_W = BUS_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s0_sel,
    input  logic              s1_sel,
    input  logic              m_wr,
    input  logic [DATA_W-1:0] s0_dout,
    input  logic [DATA_W-1:0] s1_dout,
    output logic [DATA_W-1:0] m_din
);

    logic [1:0] rd_sel;

    // Capturing the select here (rather than the grant) keeps the return
    // data tied to the transfer that issued it, even if the grant switches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_sel <= SEL_NONE;
        end else begin
            rd_sel <= {s1_sel, s0_sel} & {2{~m_wr}};
        end
    end

    // Both selects set is a decoder fault; return zero rather than a blend.
    always_comb begin
        m_din = '0;
        case (rd_sel)
            SEL_S0:  m_din = s0_dout;
            SEL_S1:  m_din = s1_dout;
            default: m_din = '0;
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
// Master-side front end of the shared system bus. Arbitrates between two
// masters with alternating tie-break and a bounded hold time, forwards the
// granted master's transfer to the decoder/slaves and returns slave read
// data one cycle after the address.
//   clk, reset                       : clock, async active-high reset
//   m0_req/wr/address/dout           : master 0 request side
//   m1_req/wr/address/dout           : master 1 request side
//   m0_grant, m1_grant               : registered grants
//   m_req/m_wr/m_address/m_dout      : forwarded transfer
//   s0_sel, s1_sel, s0_dout, s1_dout : decoder selects and slave read data
//   m_din                            : read data to both masters
// ---------------------------------------------------------------------------
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W   = BUS_ADDR_W,
    parameter int DATA_W   = BUS_DATA_W,
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [DATA_W-1:0] m0_dout,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [DATA_W-1:0] m1_dout,
    output logic              m0_grant,
    output logic              m1_grant,
    output logic              m_req,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_address,
    output logic [DATA_W-1:0] m_dout,
    input  logic              s0_sel,
    input  logic              s1_sel,
    input  logic [DATA_W-1:0] s0_dout,
    input  logic [DATA_W-1:0] s1_dout,
    output logic [DATA_W-1:0] m_din
);

    localparam int               HC_W      = $clog2(MAX_HOLD);
    localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(MAX_HOLD - 1);

    arb_state_t      state;
    logic [HC_W-1:0] hold_cnt;
    logic            last_grant;   // 0: m0 granted last, 1: m1 granted last

    // Arbiter FSM. Grants are registered alongside the state so they are
    // glitch-free Moore outputs. hold_cnt counts grant cycles beyond the
    // first; reaching HOLD_LAST means MAX_HOLD cycles have been served.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            m0_grant   <= 1'b0;
            m1_grant   <= 1'b0;
            hold_cnt   <= '0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    hold_cnt <= '0;
                    // On a tie, last_grant==1 favours m0 and vice versa.
                    if (m0_req && (!m1_req || last_grant)) begin
                        state      <= ST_GRANT0;
                        m0_grant   <= 1'b1;
                        m1_grant   <= 1'b0;
                        last_grant <= 1'b0;
                    end else if (m1_req) begin
                        state      <= ST_GRANT1;
                        m0_grant   <= 1'b0;
                        m1_grant   <= 1'b1;
                        last_grant <= 1'b1;
                    end
                end
                ST_GRANT0: begin
                    if (m1_req && (!m0_req || hold_cnt == HOLD_LAST)) begin
                        state      <= ST_GRANT1;
                        m0_grant   <= 1'b0;
                        m1_grant   <= 1'b1;
                        hold_cnt   <= '0;
                        last_grant <= 1'b1;
                    end else if (!m0_req) begin
                        state    <= ST_IDLE;
                        m0_grant <= 1'b0;
                        m1_grant <= 1'b0;
                        hold_cnt <= '0;
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + HC_W'(1);
                    end
                end
                ST_GRANT1: begin
                    if (m0_req && (!m1_req || hold_cnt == HOLD_LAST)) begin
                        state      <= ST_GRANT0;
                        m0_grant   <= 1'b1;
                        m1_grant   <= 1'b0;
                        hold_cnt   <= '0;
                        last_grant <= 1'b0;
                    end else if (!m1_req) begin
                        state    <= ST_IDLE;
                        m0_grant <= 1'b0;
                        m1_grant <= 1'b0;
                        hold_cnt <= '0;
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + HC_W'(1);
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    m0_grant <= 1'b0;
                    m1_grant <= 1'b0;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

    // Forward mux. Passing the live req through means a master that drops
    // req while still granted produces no decoder select.
    always_comb begin
        m_req     = 1'b0;
        m_wr      = 1'b0;
        m_address = '0;
        m_dout    = '0;
        case (state)
            ST_GRANT0: begin
                m_req     = m0_req;
                m_wr      = m0_wr;
                m_address = m0_address;
                m_dout    = m0_dout;
            end
            ST_GRANT1: begin
                m_req     = m1_req;
                m_wr      = m1_wr;
                m_address = m1_address;
                m_dout    = m1_dout;
            end
            default: ;
        endcase
    end

    bus_rdata_mux #(
        .DATA_W (DATA_W)
    ) u_rdata_mux (
        .clk     (clk),
        .reset   (reset),
        .s0_sel  (s0_sel),
        .s1_sel  (s1_sel),
        .m_wr    (m_wr),
        .s0_dout (s0_dout),
        .s1_dout (s1_dout),
        .m_din   (m_din)
    );

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
// Directed bench for bus_arbiter. Inputs are driven at the falling edge and
// outputs are sampled there, away from the rising active edge. The bench
// plays the role of the address decoder by driving s0_sel/s1_sel.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 32;
    localparam int MAX_HOLD = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              m0_req, m0_wr, m1_req, m1_wr;
    logic [ADDR_W-1:0] m0_address, m1_address;
    logic [DATA_W-1:0] m0_dout, m1_dout;
    logic              m0_grant, m1_grant;
    logic              m_req, m_wr;
    logic [ADDR_W-1:0] m_address;
    logic [DATA_W-1:0] m_dout;
    logic              s0_sel, s1_sel;
    logic [DATA_W-1:0] s0_dout, s1_dout;
    logic [DATA_W-1:0] m_din;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt;

    always #5 clk = ~clk;

    bus_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .m0_req     (m0_req),
        .m0_wr      (m0_wr),
        .m0_address (m0_address),
        .m0_dout    (m0_dout),
        .m1_req     (m1_req),
        .m1_wr      (m1_wr),
        .m1_address (m1_address),
        .m1_dout    (m1_dout),
        .m0_grant   (m0_grant),
        .m1_grant   (m1_grant),
        .m_req      (m_req),
        .m_wr       (m_wr),
        .m_address  (m_address),
        .m_dout     (m_dout),
        .s0_sel     (s0_sel),
        .s1_sel     (s1_sel),
        .s0_dout    (s0_dout),
        .s1_dout    (s1_dout),
        .m_din      (m_din)
    );

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m0_req = 1'b0; m0_wr = 1'b0; m0_address = '0; m0_dout = '0;
        m1_req = 1'b0; m1_wr = 1'b0; m1_address = '0; m1_dout = '0;
        s0_sel = 1'b0; s1_sel = 1'b0; s0_dout = '0; s1_dout = '0;
    endtask

    // Holds reset across one rising edge and releases it at a falling edge.
    task automatic pulse_reset();
        reset = 1'b1;
        mid();
        reset = 1'b0;
    endtask

    initial begin
        // Reset with m0 requesting.
        idle_inputs();
        m0_req = 1'b1;
        reset  = 1'b1;
        mid();
        mid();
        check_eq("rst_m0_grant", m0_grant, 0);
        check_eq("rst_m1_grant", m1_grant, 0);
        check_eq("rst_m_req", m_req, 0);
        check_eq("rst_m_din", m_din, 0);
        reset = 1'b0;
        mid();
        check_eq("post_rst_m0_grant", m0_grant, 1);

        // Tie from IDLE goes to m0, then hand over without an IDLE bubble.
        idle_inputs();
        m0_req = 1'b1; m1_req = 1'b1;
        pulse_reset();
        mid();
        check_eq("tie_m0_grant", m0_grant, 1);
        check_eq("tie_m1_grant", m1_grant, 0);
        check_eq("tie_m_req", m_req, 1);
        m0_req = 1'b0;
        #1;
        check_eq("drop_req_m_req", m_req, 0);
        mid();
        check_eq("handover_m1_grant", m1_grant, 1);
        check_eq("handover_m0_grant", m0_grant, 0);
        m1_req = 1'b0;
        mid();
        check_eq("idle_grants", {m1_grant, m0_grant}, 0);
        m0_req = 1'b1; m1_req = 1'b1;
        mid();
        check_eq("tie2_m0_grant", m0_grant, 1);

        // Forced handover after MAX_HOLD cycles, both directions.
        idle_inputs();
        m0_req = 1'b1; m1_req = 1'b1;
        pulse_reset();
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            mid();
            if (m1_grant) break;
            if (m0_grant) cnt++;
        end
        check_eq("hold_m0_cycles", cnt, 16);
        check_eq("hold_m1_granted", m1_grant, 1);
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
            mid();
            if (m0_grant) break;
            if (m1_grant) cnt++;
        end
        check_eq("hold_m1_cycles", cnt, 16);
        check_eq("hold_m0_regranted", m0_grant, 1);

        // Lone master keeps the bus; hold counter saturates.
        idle_inputs();
        m1_req = 1'b1; m1_address = 16'h4242;
        pulse_reset();
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            mid();
            if (m1_grant) cnt++;
        end
        check_eq("solo_m1_cycles", cnt, 40);
        check_eq("solo_hold_cnt", dut.hold_cnt, 15);
        check_eq("solo_m_address", m_address, 32'h4242);

        // Reads from s0 then s1 with one cycle of latency.
        idle_inputs();
        m0_req = 1'b1;
        pulse_reset();
        mid();
        m0_address = 16'h0010; s0_sel = 1'b1; s0_dout = 32'hDEADBEEF;
        #1;
        check_eq("rd0_m_address", m_address, 32'h0010);
        check_eq("rd0_not_yet", m_din, 0);
        mid();
        s0_sel = 1'b0; m0_address = 16'h7004; s1_sel = 1'b1;
        #1;
        check_eq("rd0_m_din", m_din, 32'hDEADBEEF);
        mid();
        s1_sel = 1'b0; s1_dout = 32'h12345678;
        #1;
        check_eq("rd1_m_din", m_din, 32'h12345678);

        // Write returns nothing, no select returns nothing, both selects zero.
        m0_wr = 1'b1; m0_address = 16'h0020; s0_sel = 1'b1;
        s0_dout = 32'hAAAA5555; s1_dout = '0;
        mid();
        s0_sel = 1'b0;
        #1;
        check_eq("wr_m_din", m_din, 0);
        m0_wr = 1'b0; m0_address = 16'h0900;
        mid();
        #1;
        check_eq("nosel_m_din", m_din, 0);
        s0_sel = 1'b1; s1_sel = 1'b1; s1_dout = 32'h55AA55AA;
        mid();
        s0_sel = 1'b0; s1_sel = 1'b0;
        #1;
        check_eq("bothsel_m_din", m_din, 0);

        // Async reset mid-GRANT1 drops everything, including in-flight data.
        idle_inputs();
        m1_req = 1'b1; m1_dout = 32'h11111111;
        pulse_reset();
        mid();
        m1_address = 16'h7008; s1_sel = 1'b1;
        #1;
        check_eq("g1_m_dout", m_dout, 32'h11111111);
        mid();
        s1_sel = 1'b0; s1_dout = 32'hCAFEF00D;
        #1;
        check_eq("g1_m_din", m_din, 32'hCAFEF00D);
        #1;
        reset = 1'b1;
        #1;
        check_eq("arst_m1_grant", m1_grant, 0);
        check_eq("arst_m_req", m_req, 0);
        check_eq("arst_m_address", m_address, 0);
        check_eq("arst_m_dout", m_dout, 0);
        check_eq("arst_m_din", m_din, 0);
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
